// File: rtl/uart_baud_gen_frac_if.sv
// Control and strobe bundle between the fractional baud generator and its UART user.
// Inputs are sampled on every rising clk edge. Outputs are registered one-cycle
// strobes, plus a sticky error flag. This port has no valid/ready handshake.
interface uart_baud_gen_frac_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 8
);
    logic              en;
    logic              cfg_load;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              osr_sel;
    logic              phase_clr;
    logic              os_tick;
    logic              mid_tick;
    logic              bit_tick;
    logic              cfg_err;

    modport master (
        output en, cfg_load, div_int, div_frac, osr_sel, phase_clr,
        input  os_tick, mid_tick, bit_tick, cfg_err
    );

    modport slave (
        input  en, cfg_load, div_int, div_frac, osr_sel, phase_clr,
        output os_tick, mid_tick, bit_tick, cfg_err
    );
endinterface

// File: rtl/uart_baud_gen_frac.sv
// Fractional-N baud tick generator: an integer period counter is stretched by one clock
// whenever the fractional accumulator carries, giving a drift-free mean oversample period.
module uart_baud_gen_frac #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUDRATE   = 625000,
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_baud_gen_frac_if.slave   bif
);
    localparam int              DEF_INT_I = CLOCK_FREQ / (BAUDRATE * 16);
    localparam logic [DIV_W-1:0] DEF_INT  = DIV_W'(DEF_INT_I);
    localparam logic [DIV_W-1:0] MIN_INT  = DIV_W'(2);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W:0]    period_q, period_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [3:0]        os_cnt_q, os_cnt_d;
    logic [DIV_W-1:0]  div_int_q, div_int_d;
    logic [FRAC_W-1:0] div_frac_q, div_frac_d;
    logic              osr_q, osr_d;
    logic              os_tick_q, os_tick_d;
    logic              mid_tick_q, mid_tick_d;
    logic              bit_tick_q, bit_tick_d;
    logic              cfg_err_q, cfg_err_d;

    logic [FRAC_W:0]   acc_sum;
    logic [3:0]        os_last;
    logic [3:0]        os_mid;
    logic              int_too_small;
    logic [DIV_W-1:0]  int_clamped;
    logic              period_end;

    always_comb begin
        acc_sum       = {1'b0, acc_q} + {1'b0, div_frac_q};
        os_last       = osr_q ? 4'd7 : 4'd15;
        os_mid        = osr_q ? 4'd3 : 4'd7;
        int_too_small = (bif.div_int < MIN_INT);
        int_clamped   = int_too_small ? MIN_INT : bif.div_int;
        // period_q never drops below 2, so period_q - 1 cannot underflow
        period_end    = ({1'b0, cnt_q} == (period_q - {{DIV_W{1'b0}}, 1'b1}));

        cnt_d      = cnt_q;
        period_d   = period_q;
        acc_d      = acc_q;
        os_cnt_d   = os_cnt_q;
        div_int_d  = div_int_q;
        div_frac_d = div_frac_q;
        osr_d      = osr_q;
        cfg_err_d  = cfg_err_q;
        os_tick_d  = 1'b0;
        mid_tick_d = 1'b0;
        bit_tick_d = 1'b0;

        if (bif.cfg_load) begin
            div_int_d  = int_clamped;
            div_frac_d = bif.div_frac;
            osr_d      = bif.osr_sel;
            cfg_err_d  = cfg_err_q | int_too_small;
            cnt_d      = '0;
            acc_d      = '0;
            os_cnt_d   = '0;
            period_d   = {1'b0, int_clamped};
        end else if (bif.phase_clr || !bif.en) begin
            cnt_d    = '0;
            acc_d    = '0;
            os_cnt_d = '0;
            period_d = {1'b0, div_int_q};
        end else if (period_end) begin
            // The carry out of the accumulator lengthens the next period by one clock
            cnt_d      = '0;
            acc_d      = acc_sum[FRAC_W-1:0];
            period_d   = {1'b0, div_int_q} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]};
            os_tick_d  = 1'b1;
            mid_tick_d = (os_cnt_q == os_mid);
            bit_tick_d = (os_cnt_q == os_last);
            os_cnt_d   = (os_cnt_q == os_last) ? 4'd0 : os_cnt_q + 4'd1;
        end else begin
            cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            period_q   <= {1'b0, DEF_INT};
            acc_q      <= '0;
            os_cnt_q   <= '0;
            div_int_q  <= DEF_INT;
            div_frac_q <= '0;
            osr_q      <= 1'b0;
            os_tick_q  <= 1'b0;
            mid_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            acc_q      <= acc_d;
            os_cnt_q   <= os_cnt_d;
            div_int_q  <= div_int_d;
            div_frac_q <= div_frac_d;
            osr_q      <= osr_d;
            os_tick_q  <= os_tick_d;
            mid_tick_q <= mid_tick_d;
            bit_tick_q <= bit_tick_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign bif.os_tick  = os_tick_q;
    assign bif.mid_tick = mid_tick_q;
    assign bif.bit_tick = bit_tick_q;
    assign bif.cfg_err  = cfg_err_q;
endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac: a table of divisor settings with hand-computed
// strobe counts and first-strobe positions, followed by phase_clr, enable and reset sequences.
module tb_uart_baud_gen_frac;
  logic clk;
  logic rst_n;
  int n_checks;
  int n_fail;

  uart_baud_gen_frac_if #(.DIV_W(16), .FRAC_W(8)) bif ();

  uart_baud_gen_frac #(
    .CLOCK_FREQ(100_000_000),
    .BAUDRATE  (625000),
    .DIV_W     (16),
    .FRAC_W    (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bif  (bif.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] div_int;
    logic [7:0]  div_frac;
    logic        osr_sel;
    int          n_cyc;
    int          exp_os;
    int          exp_mid;
    int          exp_bit;
    int          exp_first_os;
    int          exp_first_mid;
    int          exp_first_bit;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];
  logic [15:0] exp_q[$];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // driver tasks
  task automatic do_load(input logic [15:0] di, input logic [7:0] df, input logic osr);
    bif.en       = 1'b1;
    bif.div_int  = di;
    bif.div_frac = df;
    bif.osr_sel  = osr;
    bif.cfg_load = 1'b1;
    @(posedge clk);
    #1;
    bif.cfg_load = 1'b0;
  endtask

  // Sample n edges; positions are counted in edges after the starting edge (0 = not seen)
  task automatic run_window(input int n,
                            output int c_os, output int c_mid, output int c_bit,
                            output int f_os, output int f_mid, output int f_bit);
    c_os = 0; c_mid = 0; c_bit = 0; f_os = 0; f_mid = 0; f_bit = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (bif.os_tick) begin
        c_os++;
        if (f_os == 0) f_os = i;
      end
      if (bif.mid_tick) begin
        c_mid++;
        if (f_mid == 0) f_mid = i;
      end
      if (bif.bit_tick) begin
        c_bit++;
        if (f_bit == 0) f_bit = i;
      end
    end
  endtask

  initial begin
    int c_os, c_mid, c_bit, f_os, f_mid, f_bit;
    int last_t, t, seen, quiet;
    logic [15:0] exp_iv;

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{16'd4, 8'h00, 1'b0,  256,   64,  4,  4, 4, 32,  64, 1'b0};
    vecs[1] = '{16'd3, 8'h80, 1'b0, 3500, 1000, 63, 62, 3, 27,  55, 1'b0};
    vecs[2] = '{16'd5, 8'h00, 1'b1,  400,   80, 10, 10, 5, 20,  40, 1'b0};
    vecs[3] = '{16'd2, 8'h40, 1'b1,  100,   44,  6,  5, 2,  8,  17, 1'b0};
    vecs[4] = '{16'd1, 8'h00, 1'b0,   64,   32,  2,  2, 2, 16,  32, 1'b1};
    vecs[5] = '{16'd0, 8'h00, 1'b0,   64,   32,  2,  2, 2, 16,  32, 1'b1};

    rst_n         = 1'b0;
    bif.en        = 1'b0;
    bif.cfg_load  = 1'b0;
    bif.div_int   = '0;
    bif.div_frac  = '0;
    bif.osr_sel   = 1'b0;
    bif.phase_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_os_tick", int'(bif.os_tick), 0);
    check("reset_mid_tick", int'(bif.mid_tick), 0);
    check("reset_bit_tick", int'(bif.bit_tick), 0);
    check("reset_cfg_err", int'(bif.cfg_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // table-driven rows
    for (int v = 0; v < 6; v++) begin
      do_load(vecs[v].div_int, vecs[v].div_frac, vecs[v].osr_sel);
      check($sformatf("row%0d_load_no_strobe", v), int'(bif.os_tick), 0);
      run_window(vecs[v].n_cyc, c_os, c_mid, c_bit, f_os, f_mid, f_bit);
      check($sformatf("row%0d_os_count", v), c_os, vecs[v].exp_os);
      check($sformatf("row%0d_mid_count", v), c_mid, vecs[v].exp_mid);
      check($sformatf("row%0d_bit_count", v), c_bit, vecs[v].exp_bit);
      check($sformatf("row%0d_first_os", v), f_os, vecs[v].exp_first_os);
      check($sformatf("row%0d_first_mid", v), f_mid, vecs[v].exp_first_mid);
      check($sformatf("row%0d_first_bit", v), f_bit, vecs[v].exp_first_bit);
      check($sformatf("row%0d_cfg_err", v), int'(bif.cfg_err), int'(vecs[v].exp_err));
    end

    // valid load after an error: cfg_err stays sticky
    do_load(16'd4, 8'h00, 1'b0);
    run_window(4, c_os, c_mid, c_bit, f_os, f_mid, f_bit);
    check("err_sticky_after_good_load", int'(bif.cfg_err), 1);

    // fractional period sequence 3,3,4,3,4,... scored interval by interval
    for (int k = 1; k <= 20; k++) begin
      exp_iv = (k == 1 || (k % 2) == 0) ? 16'd3 : 16'd4;
      exp_q.push_back(exp_iv);
    end
    do_load(16'd3, 8'h80, 1'b0);
    last_t = 0;
    t      = 0;
    seen   = 0;
    while (seen < 20 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
      if (bif.os_tick) begin
        seen++;
        exp_iv = exp_q.pop_front();
        check($sformatf("frac_interval_%0d", seen), t - last_t, int'(exp_iv));
        last_t = t;
      end
    end
    check("frac_intervals_seen", seen, 20);

    // phase_clr landing exactly where the 8th tick (a mid_tick) would have fired
    do_load(16'd4, 8'h00, 1'b0);
    run_window(31, c_os, c_mid, c_bit, f_os, f_mid, f_bit);
    check("pre_clr_os_count", c_os, 7);
    bif.phase_clr = 1'b1;
    @(posedge clk);
    #1;
    bif.phase_clr = 1'b0;
    check("phase_clr_no_os", int'(bif.os_tick), 0);
    check("phase_clr_no_mid", int'(bif.mid_tick), 0);
    run_window(64, c_os, c_mid, c_bit, f_os, f_mid, f_bit);
    check("phase_clr_first_os", f_os, 4);
    check("phase_clr_first_mid", f_mid, 32);
    check("phase_clr_first_bit", f_bit, 64);

    // en low mid-period holds strobes off; rising en restarts the phase
    run_window(6, c_os, c_mid, c_bit, f_os, f_mid, f_bit);
    bif.en = 1'b0;
    quiet  = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      quiet += int'(bif.os_tick) + int'(bif.mid_tick) + int'(bif.bit_tick);
    end
    check("en_low_strobes", quiet, 0);
    bif.en = 1'b1;
    run_window(64, c_os, c_mid, c_bit, f_os, f_mid, f_bit);
    check("en_rise_first_os", f_os, 4);
    check("en_rise_first_bit", f_bit, 64);

    // async reset while a strobe is high; then default divisor from a fresh start
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(posedge clk);
      #1;
      if (bif.os_tick) seen = 1;
    end
    check("pre_reset_strobe_seen", seen, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_os_tick", int'(bif.os_tick), 0);
    check("async_reset_cfg_err", int'(bif.cfg_err), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_window(160, c_os, c_mid, c_bit, f_os, f_mid, f_bit);
    check("post_reset_first_os", f_os, 10);
    check("post_reset_first_mid", f_mid, 80);
    check("post_reset_first_bit", f_bit, 160);
    check("post_reset_os_count", c_os, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
